// File: rtl/byte_strip_pkg.sv
// Shared definitions for the byte_strip transmit path: symbol codes, scheduler states, source select.
// The SKP states exist only when BSS_SKP_EN is defined.
package byte_strip_pkg;

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;

`ifdef BSS_SKP_EN
  typedef enum logic [2:0] {IDLE, PAYLOAD, PAD, SKP_COM, SKP_SKP} sched_state_t;
`else
  typedef enum logic [2:0] {IDLE, PAYLOAD, PAD} sched_state_t;
`endif

  typedef enum logic {SRC_TLP = 1'b0, SRC_DLLP = 1'b1} src_t;

endpackage

// File: rtl/byte_strip_sched_if.sv
// Source handshakes plus the symbol stream toward byte_strip.
// master = sources/sink side, slave = the scheduler.
interface byte_strip_sched_if #(
  parameter int NUM_LANES = 4
) ();
  localparam int LPW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic           TLP_REQ;
  logic [7:0]     TLP_DATA;
  logic           TLP_LAST;
  logic           TLP_ACK;
  logic           DLLP_REQ;
  logic [7:0]     DLLP_DATA;
  logic           DLLP_LAST;
  logic           DLLP_ACK;
  logic [7:0]     D;
  logic           DK;
  logic [LPW-1:0] LANE_POS;
  logic           ERR_UNDERFLOW;

  modport master (
    output TLP_REQ, TLP_DATA, TLP_LAST, DLLP_REQ, DLLP_DATA, DLLP_LAST,
    input  TLP_ACK, DLLP_ACK, D, DK, LANE_POS, ERR_UNDERFLOW
  );

  modport slave (
    input  TLP_REQ, TLP_DATA, TLP_LAST, DLLP_REQ, DLLP_DATA, DLLP_LAST,
    output TLP_ACK, DLLP_ACK, D, DK, LANE_POS, ERR_UNDERFLOW
  );
endinterface

// File: rtl/byte_strip_rr_arb.sv
// Two-way round-robin arbiter between the TLP and DLLP sources.
// The pointer only moves when a tie is actually granted.
module byte_strip_rr_arb
  import byte_strip_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic tlp_req,
  input  logic dllp_req,
  input  logic take,
  output logic grant_valid,
  output src_t grant_sel
);

  src_t ptr_q;

  always_comb begin
    grant_valid = tlp_req | dllp_req;
    grant_sel   = SRC_DLLP;
    if (tlp_req && dllp_req) begin
      grant_sel = ptr_q;
    end else if (tlp_req) begin
      grant_sel = SRC_TLP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q <= SRC_DLLP;
    end else if (take && tlp_req && dllp_req) begin
      ptr_q <= (ptr_q == SRC_TLP) ? SRC_DLLP : SRC_TLP;
    end
  end

endmodule

// File: rtl/byte_strip_sched.sv
// Framing scheduler feeding byte_strip one symbol per clock, lane-aligned STP/SDP ... END/EDB.
// Define BSS_SKP_EN to enable periodic COM/SKP ordered-set insertion.
module byte_strip_sched
  import byte_strip_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_CNT_W    = 11
) (
  input  logic CLK,
  input  logic RESET,
  byte_strip_sched_if.slave bus
);

  localparam int LPW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LPW-1:0] LAST_LANE = LPW'(NUM_LANES - 1);

  if (SKP_INTERVAL < 1 || SKP_INTERVAL >= (1 << SKP_CNT_W)) begin : g_bad_cfg
    $error("byte_strip_sched: SKP_CNT_W too narrow for SKP_INTERVAL");
  end

  sched_state_t   state_q, state_d;
  logic [LPW-1:0] pos_q, pos_next, lane_q;
  logic [7:0]     d_q, d_d;
  logic           dk_q, dk_d;
  logic           err_q, err_d;
  src_t           sel_q, sel_d;
  logic           null_q, null_d;
  logic           tlp_ack, dllp_ack;
  logic           grant_take, grant_valid;
  src_t           grant_sel;
  logic           sel_req, sel_last;
  logic [7:0]     sel_data;
  logic           skp_pending;

  byte_strip_rr_arb u_arb (
    .CLK         (CLK),
    .RESET       (RESET),
    .tlp_req     (bus.TLP_REQ),
    .dllp_req    (bus.DLLP_REQ),
    .take        (grant_take),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // pos_q is the lane the symbol registered this cycle will occupy.
  assign pos_next = (NUM_LANES == 1) ? '0 : pos_q + LPW'(1);

  assign sel_req  = (sel_q == SRC_TLP) ? bus.TLP_REQ  : bus.DLLP_REQ;
  assign sel_data = (sel_q == SRC_TLP) ? bus.TLP_DATA : bus.DLLP_DATA;
  assign sel_last = (sel_q == SRC_TLP) ? bus.TLP_LAST : bus.DLLP_LAST;

`ifdef BSS_SKP_EN
  logic [SKP_CNT_W-1:0] skp_cnt_q;
  logic [1:0]           row_q;
  logic                 skp_done;

  // An expiry while a request is already pending is simply absorbed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      skp_cnt_q   <= '0;
      skp_pending <= 1'b0;
    end else if (skp_cnt_q == SKP_CNT_W'(SKP_INTERVAL - 1)) begin
      skp_cnt_q   <= '0;
      skp_pending <= 1'b1;
    end else begin
      skp_cnt_q <= skp_cnt_q + SKP_CNT_W'(1);
      if (skp_done) skp_pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      row_q <= '0;
    end else if (state_q == SKP_SKP && pos_q == LAST_LANE) begin
      row_q <= (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
    end
  end
`else
  assign skp_pending = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    d_d        = SYM_IDL;
    dk_d       = 1'b1;
    err_d      = 1'b0;
    sel_d      = sel_q;
    null_d     = null_q;
    grant_take = 1'b0;
    tlp_ack    = 1'b0;
    dllp_ack   = 1'b0;
`ifdef BSS_SKP_EN
    skp_done   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pos_q == '0) begin
          if (skp_pending) begin
`ifdef BSS_SKP_EN
            d_d     = SYM_COM;
            state_d = (NUM_LANES == 1) ? SKP_SKP : SKP_COM;
`endif
          end else if (grant_valid) begin
            grant_take = 1'b1;
            sel_d      = grant_sel;
            null_d     = 1'b0;
            d_d        = (grant_sel == SRC_TLP) ? SYM_STP : SYM_SDP;
            state_d    = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (sel_req) begin
          tlp_ack  = (sel_q == SRC_TLP);
          dllp_ack = (sel_q == SRC_DLLP);
          d_d      = sel_data;
          dk_d     = 1'b0;
          if (sel_last) state_d = PAD;
        end else begin
          d_d     = SYM_PAD;
          null_d  = 1'b1;
          state_d = PAD;
        end
      end
      // The end token must land on the last lane; a nullified packet ends in EDB.
      PAD: begin
        if (pos_q == LAST_LANE) begin
          d_d     = null_q ? SYM_EDB : SYM_END;
          err_d   = null_q;
          state_d = IDLE;
        end else begin
          d_d = SYM_PAD;
        end
      end
`ifdef BSS_SKP_EN
      SKP_COM: begin
        d_d = SYM_COM;
        if (pos_q == LAST_LANE) state_d = SKP_SKP;
      end
      SKP_SKP: begin
        d_d = SYM_SKP;
        if (pos_q == LAST_LANE && row_q == 2'd2) begin
          skp_done = 1'b1;
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      pos_q   <= '0;
      lane_q  <= '0;
      d_q     <= SYM_IDL;
      dk_q    <= 1'b1;
      err_q   <= 1'b0;
      sel_q   <= SRC_TLP;
      null_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_next;
      lane_q  <= pos_q;
      d_q     <= d_d;
      dk_q    <= dk_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      null_q  <= null_d;
    end
  end

  assign bus.TLP_ACK       = tlp_ack;
  assign bus.DLLP_ACK      = dllp_ack;
  assign bus.D             = d_q;
  assign bus.DK            = dk_q;
  assign bus.LANE_POS      = lane_q;
  assign bus.ERR_UNDERFLOW = err_q;

endmodule

// File: tb/tb_byte_strip_sched.sv
// Directed bench for byte_strip_sched (NUM_LANES=4); SKP insertion is exercised when BSS_SKP_EN is defined.
module tb_byte_strip_sched;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int checks = 0;
  int failures = 0;
  int badSym = 0;
  logic [7:0] tlpQ[$];
  logic [7:0] dllpQ[$];
  logic tlpStall = 1'b0;

`ifdef BSS_SKP_EN
  localparam int SKPI = 16;
`else
  localparam int SKPI = 1180;
`endif

  byte_strip_sched_if #(.NUM_LANES(4)) bus ();

  byte_strip_sched #(.NUM_LANES(4), .SKP_INTERVAL(SKPI), .SKP_CNT_W(11)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (!RESET && bus.DK && (bus.D == 8'hBC || bus.D == 8'h1C)) badSym++;

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    bus.TLP_REQ   = (tlpQ.size() > 0) && !tlpStall;
    bus.TLP_DATA  = (tlpQ.size() > 0) ? tlpQ[0] : 8'h00;
    bus.TLP_LAST  = (tlpQ.size() == 1);
    bus.DLLP_REQ  = (dllpQ.size() > 0);
    bus.DLLP_DATA = (dllpQ.size() > 0) ? dllpQ[0] : 8'h00;
    bus.DLLP_LAST = (dllpQ.size() == 1);
  endtask

  task automatic checkOutput(string tag, logic [7:0] eD, logic eK, int eLane,
                             logic eTA, logic eDA, logic eErr);
    checkVal({tag, "/D"}, 32'(bus.D), 32'(eD));
    checkVal({tag, "/DK"}, 32'(bus.DK), 32'(eK));
    checkVal({tag, "/LANE"}, 32'(bus.LANE_POS), eLane);
    checkVal({tag, "/TACK"}, 32'(bus.TLP_ACK), 32'(eTA));
    checkVal({tag, "/DACK"}, 32'(bus.DLLP_ACK), 32'(eDA));
    checkVal({tag, "/ERR"}, 32'(bus.ERR_UNDERFLOW), 32'(eErr));
  endtask

  // One clock: drive sources, check the current outputs, then consume acked bytes.
  task automatic step(string tag, logic [7:0] eD, logic eK, int eLane,
                      logic eTA, logic eDA, logic eErr = 1'b0);
    logic tA, dA;
    applyStimulus();
    #1;
    checkOutput(tag, eD, eK, eLane, eTA, eDA, eErr);
    tA = bus.TLP_ACK;
    dA = bus.DLLP_ACK;
    @(posedge CLK);
    #1;
    if (tA && tlpQ.size() > 0) void'(tlpQ.pop_front());
    if (dA && dllpQ.size() > 0) void'(dllpQ.pop_front());
  endtask

  task automatic doReset();
    RESET = 1'b1;
    applyStimulus();
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    applyStimulus();

    $display("[TB] reset and idle lanes");
    doReset();
    step("idle.c1", 8'h7C, 1, 0, 0, 0);
    step("idle.c2", 8'h7C, 1, 0, 0, 0);
    step("idle.c3", 8'h7C, 1, 1, 0, 0);
    step("idle.c4", 8'h7C, 1, 2, 0, 0);
    step("idle.c5", 8'h7C, 1, 3, 0, 0);
    step("idle.c6", 8'h7C, 1, 0, 0, 0);

    $display("[TB] 5-byte TLP");
    tlpQ = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    doReset();
    step("tlp5.c1", 8'h7C, 1, 0, 0, 0);
    step("tlp5.c2", 8'hFB, 1, 0, 1, 0);
    step("tlp5.c3", 8'hA0, 0, 1, 1, 0);
    step("tlp5.c4", 8'hA1, 0, 2, 1, 0);
    step("tlp5.c5", 8'hA2, 0, 3, 1, 0);
    step("tlp5.c6", 8'hA3, 0, 0, 1, 0);
    step("tlp5.c7", 8'hA4, 0, 1, 0, 0);
    step("tlp5.c8", 8'hF7, 1, 2, 0, 0);
    step("tlp5.c9", 8'hFD, 1, 3, 0, 0);
    step("tlp5.c10", 8'h7C, 1, 0, 0, 0);

    $display("[TB] 2-byte DLLP");
    dllpQ = '{8'hD0, 8'hD1};
    doReset();
    step("dllp2.c1", 8'h7C, 1, 0, 0, 0);
    step("dllp2.c2", 8'h5C, 1, 0, 0, 1);
    step("dllp2.c3", 8'hD0, 0, 1, 0, 1);
    step("dllp2.c4", 8'hD1, 0, 2, 0, 0);
    step("dllp2.c5", 8'hFD, 1, 3, 0, 0);
    step("dllp2.c6", 8'h7C, 1, 0, 0, 0);

    $display("[TB] arbitration ties");
    tlpQ  = '{8'hB0, 8'hB1};
    dllpQ = '{8'hC0, 8'hC1};
    doReset();
    step("tie.c1", 8'h7C, 1, 0, 0, 0);
    step("tie.c2", 8'h5C, 1, 0, 0, 1);
    step("tie.c3", 8'hC0, 0, 1, 0, 1);
    step("tie.c4", 8'hC1, 0, 2, 0, 0);
    step("tie.c5", 8'hFD, 1, 3, 0, 0);
    step("tie.c6", 8'hFB, 1, 0, 1, 0);
    step("tie.c7", 8'hB0, 0, 1, 1, 0);
    step("tie.c8", 8'hB1, 0, 2, 0, 0);
    tlpQ  = '{8'hB2, 8'hB3};
    dllpQ = '{8'hC2, 8'hC3};
    step("tie.c9", 8'hFD, 1, 3, 0, 0);
    step("tie.c10", 8'hFB, 1, 0, 1, 0);
    step("tie.c11", 8'hB2, 0, 1, 1, 0);
    step("tie.c12", 8'hB3, 0, 2, 0, 0);
    step("tie.c13", 8'hFD, 1, 3, 0, 0);
    step("tie.c14", 8'h5C, 1, 0, 0, 1);
    step("tie.c15", 8'hC2, 0, 1, 0, 1);
    step("tie.c16", 8'hC3, 0, 2, 0, 0);
    step("tie.c17", 8'hFD, 1, 3, 0, 0);

    $display("[TB] underflow nullify");
    tlpQ = '{8'hE0, 8'hE1};
    doReset();
    step("unf.c1", 8'h7C, 1, 0, 0, 0);
    step("unf.c2", 8'hFB, 1, 0, 1, 0);
    tlpStall = 1'b1;
    step("unf.c3", 8'hE0, 0, 1, 0, 0);
    step("unf.c4", 8'hF7, 1, 2, 0, 0);
    step("unf.c5", 8'hFE, 1, 3, 0, 0, 1);
    step("unf.c6", 8'h7C, 1, 0, 0, 0, 0);
    tlpStall = 1'b0;
    tlpQ.delete();

`ifdef BSS_SKP_EN
    $display("[TB] SKP insertion after in-flight TLP");
    doReset();
    for (int k = 1; k <= 12; k++)
      step($sformatf("skp.c%0d", k), 8'h7C, 1, (k == 1) ? 0 : (k - 2) % 4, 0, 0);
    tlpQ = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
    step("skp.c13", 8'h7C, 1, 3, 0, 0);
    step("skp.c14", 8'hFB, 1, 0, 1, 0);
    step("skp.c15", 8'hF0, 0, 1, 1, 0);
    step("skp.c16", 8'hF1, 0, 2, 1, 0);
    step("skp.c17", 8'hF2, 0, 3, 1, 0);
    step("skp.c18", 8'hF3, 0, 0, 1, 0);
    step("skp.c19", 8'hF4, 0, 1, 1, 0);
    step("skp.c20", 8'hF5, 0, 2, 0, 0);
    tlpQ = '{8'h99};
    step("skp.c21", 8'hFD, 1, 3, 0, 0);
    for (int k = 0; k < 4; k++)
      step($sformatf("skp.com%0d", k), 8'hBC, 1, k, 0, 0);
    for (int k = 0; k < 12; k++)
      step($sformatf("skp.skp%0d", k), 8'h1C, 1, k % 4, 0, 0);
    step("skp.c38", 8'hFB, 1, 0, 1, 0);
    step("skp.c39", 8'h99, 0, 1, 0, 0);
    step("skp.c40", 8'hF7, 1, 2, 0, 0);
    step("skp.c41", 8'hFD, 1, 3, 0, 0);
`else
    checkVal("no_skp_symbols", 32'(badSym), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
